// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank
//   APB slave exposing NUM_REGS read/write registers of DATA_W bits each,
//   with byte strobes, optional wait states and per-register write pulses.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   psel, penable       APB select / access-phase enable
//   pwrite              1 = write, 0 = read
//   paddr               byte address; register index = paddr[ADDR_W-1:2]
//   pwdata, pstrb       write data and byte write strobes
//   prdata              read data, zero outside the READY cycle of a good read
//   pready              transfer completes this cycle (registered)
//   pslverr             error response, only asserted together with pready
//   reg_q               all registers, register i at [i*DATA_W +: DATA_W]
//   wr_pulse            one-cycle pulse per register, the cycle after a commit
//
// Note: ADDR_W must be at least SEL_W+2, where SEL_W is clog2(NUM_REGS)
// (1 for a single register).
module apb_slave_regbank #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 8,
  parameter int                NUM_REGS    = 16,
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         psel,
  input  logic                         penable,
  input  logic                         pwrite,
  input  logic [ADDR_W-1:0]            paddr,
  input  logic [DATA_W-1:0]            pwdata,
  input  logic [DATA_W/8-1:0]          pstrb,
  output logic [DATA_W-1:0]            prdata,
  output logic                         pready,
  output logic                         pslverr,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic [NUM_REGS-1:0]          wr_pulse
);

  localparam int STRB_W = DATA_W / 8;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pready_q, pready_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               err_q, err_d;
  logic               rd_q, rd_d;
  logic               addr_err;
  logic               commit;
  logic [NUM_REGS*DATA_W-1:0] reg_flat;
  logic [DATA_W-1:0]  rd_val;

  // Out-of-range index or a byte address that is not word aligned.
  assign addr_err = (32'(paddr[ADDR_W-1:2]) >= NUM_REGS) || (paddr[1:0] != 2'b00);

  // Transfer FSM. The address, its error status and the direction are all
  // captured in the setup cycle so the access phase only needs the held bus.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pready_d = 1'b0;
    sel_d    = sel_q;
    err_d    = err_q;
    rd_d     = rd_q;
    commit   = 1'b0;
    case (state_q)
      IDLE: begin
        // penable without a preceding setup is deliberately ignored here.
        if (psel && !penable) begin
          sel_d = paddr[SEL_W+1:2];
          err_d = addr_err;
          rd_d  = !pwrite;
          if (WAIT_STATES == 0) begin
            state_d  = READY;
            pready_d = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          // Master abandoned the transfer.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= 4'd1) begin
          state_d  = READY;
          pready_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      READY: begin
        state_d = IDLE;
        commit  = psel && penable && pwrite && !err_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      sel_q    <= '0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
    end
  end

  // One register plus its write pulse per generate iteration.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_W-1:0] val_q, val_d;
      logic              pulse_q, pulse_d;

      always_comb begin
        val_d   = val_q;
        pulse_d = commit && (32'(sel_q) == gi);
        if (pulse_d) begin
          for (int k = 0; k < STRB_W; k++) begin
            if (pstrb[k]) begin
              val_d[8*k +: 8] = pwdata[8*k +: 8];
            end
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          val_q   <= RESET_VAL;
          pulse_q <= 1'b0;
        end else begin
          val_q   <= val_d;
          pulse_q <= pulse_d;
        end
      end

      assign reg_flat[gi*DATA_W +: DATA_W] = val_q;
      assign wr_pulse[gi]                  = pulse_q;
    end
  endgenerate

  // Read mux; an erroring index never reaches prdata because of the gating below.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(sel_q) == i) begin
        rd_val = reg_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  assign reg_q   = reg_flat;
  assign pready  = pready_q;
  assign pslverr = pready_q && err_q;
  assign prdata  = (pready_q && rd_q && !err_q) ? rd_val : '0;

endmodule
